// File: rtl/mctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I main control: FSM states, opcode classes,
// ALUOp codes, datapath mux selects and RV32I major opcodes.
// Optional trap support is controlled by MCTRL_TRAP_EN, which adds the TRAP state.
package mctrl_pkg;

  // Main FSM states; TRAP only exists when illegal-opcode trapping is built in
  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_EXEC_LUI,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_ALU,
    ST_WB_MEM,
    ST_BRANCH,
    ST_JAL,
    ST_JALR
`ifdef MCTRL_TRAP_EN
    ,
    ST_TRAP
`endif
  } state_t;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LUI,
    CLS_AUIPC,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_ILLEGAL
  } opclass_t;

  // ALUOp codes handed to the ALU control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  // ALU operand B select (2'b11 unused)
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  // Register-file writeback source select
  localparam logic [1:0] WB_ALUOUT   = 2'b00;
  localparam logic [1:0] WB_MEMDATA  = 2'b01;
  localparam logic [1:0] WB_PC       = 2'b10;

  // RV32I major opcodes
  localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE   = 7'b0010011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;

endpackage

// File: rtl/multicycle_main_control_opcode_class_decoder.sv
// Maps a 7-bit RV32I major opcode to an instruction class; unknown opcodes are ILLEGAL.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the opcode input directly.
module opcode_class_decoder
  import mctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output opclass_t   o_class
);

  // Opcode lookup with ILLEGAL as the fall-through class
  always_comb begin
    o_class = CLS_ILLEGAL;
    case (i_opcode)
      OPC_RTYPE:  o_class = CLS_R;
      OPC_ITYPE:  o_class = CLS_I;
      OPC_LUI:    o_class = CLS_LUI;
      OPC_AUIPC:  o_class = CLS_AUIPC;
      OPC_LOAD:   o_class = CLS_LOAD;
      OPC_STORE:  o_class = CLS_STORE;
      OPC_BRANCH: o_class = CLS_BRANCH;
      OPC_JAL:    o_class = CLS_JAL;
      OPC_JALR:   o_class = CLS_JALR;
      default:    o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/mem/writeback.
// Latency: 3-5 cycles per instruction with zero memory wait; outputs are combinational from state.
// Backpressure: imem/dmem requests are held as levels until the matching ready; each wait adds one cycle.
// Build option MCTRL_TRAP_EN: illegal opcodes enter an absorbing TRAP state and raise illegal_instr.
module multicycle_main_control
  import mctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       branch_taken,
  output logic [1:0] ALUOp,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       instr_retire
`ifdef MCTRL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  state_t   r_state;
  state_t   w_state_nxt;
  opclass_t w_class;

  opcode_class_decoder u_dec (
    .i_opcode (opcode),
    .o_class  (w_class)
  );

  // State register; reset abandons any in-flight memory request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state datapath strobes; everything defaults to 0
  always_comb begin
    w_state_nxt  = r_state;
    ALUOp        = ALUOP_ADD;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RS2;
    pc_src       = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    instr_retire = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        // ALU forms PC+4 while the fetch is outstanding
        imem_req  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        ALUOp     = ALUOP_ADD;
        if (imem_ready) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          pc_src      = 1'b0;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Branch/JAL target is precomputed into ALUOut here
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        ALUOp     = ALUOP_ADD;
        case (w_class)
          CLS_R:      w_state_nxt = ST_EXEC_R;
          CLS_I:      w_state_nxt = ST_EXEC_I;
          CLS_LUI:    w_state_nxt = ST_EXEC_LUI;
          CLS_AUIPC:  w_state_nxt = ST_WB_ALU;
          CLS_LOAD:   w_state_nxt = ST_MEM_ADDR;
          CLS_STORE:  w_state_nxt = ST_MEM_ADDR;
          CLS_BRANCH: w_state_nxt = ST_BRANCH;
          CLS_JAL:    w_state_nxt = ST_JAL;
          CLS_JALR:   w_state_nxt = ST_JALR;
`ifdef MCTRL_TRAP_EN
          default:    w_state_nxt = ST_TRAP;
`else
          // Unknown opcode retires silently as a NOP
          default:    w_state_nxt = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        ALUOp       = ALUOP_RTYPE;
        w_state_nxt = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        ALUOp       = ALUOP_ITYPE;
        w_state_nxt = ST_WB_ALU;
      end
      ST_EXEC_LUI: begin
        alu_src_a   = SRC_A_ZERO;
        alu_src_b   = SRC_B_IMM;
        ALUOp       = ALUOP_ADD;
        w_state_nxt = ST_WB_ALU;
      end
      ST_MEM_ADDR: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        ALUOp       = ALUOP_ADD;
        w_state_nxt = (w_class == CLS_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          w_state_nxt = ST_WB_MEM;
        end
      end
      ST_MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (dmem_ready) begin
          instr_retire = 1'b1;
          w_state_nxt  = ST_FETCH;
        end
      end
      ST_WB_ALU: begin
        reg_write    = 1'b1;
        wb_sel       = WB_ALUOUT;
        instr_retire = 1'b1;
        w_state_nxt  = ST_FETCH;
      end
      ST_WB_MEM: begin
        reg_write    = 1'b1;
        wb_sel       = WB_MEMDATA;
        instr_retire = 1'b1;
        w_state_nxt  = ST_FETCH;
      end
      ST_BRANCH: begin
        // Comparison runs on the ALU; target already sits in ALUOut
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        ALUOp        = ALUOP_SUB;
        pc_src       = 1'b1;
        pc_write     = branch_taken;
        instr_retire = 1'b1;
        w_state_nxt  = ST_FETCH;
      end
      ST_JAL: begin
        pc_write     = 1'b1;
        pc_src       = 1'b1;
        reg_write    = 1'b1;
        wb_sel       = WB_PC;
        instr_retire = 1'b1;
        w_state_nxt  = ST_FETCH;
      end
      ST_JALR: begin
        // Target goes straight from the ALU; bit 0 is cleared in the datapath
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_IMM;
        ALUOp        = ALUOP_ADD;
        pc_src       = 1'b0;
        pc_write     = 1'b1;
        reg_write    = 1'b1;
        wb_sel       = WB_PC;
        instr_retire = 1'b1;
        w_state_nxt  = ST_FETCH;
      end
`ifdef MCTRL_TRAP_EN
      ST_TRAP: begin
        w_state_nxt = ST_TRAP;
      end
`endif
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

`ifdef MCTRL_TRAP_EN
  // TRAP is absorbing, so decoding the state is already sticky until reset
  assign illegal_instr = (r_state == ST_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle vector table plus reset/trap sequences.
// Inputs are driven on the falling edge and outputs compared 1 time unit later.
// Honours MCTRL_TRAP_EN for the illegal-opcode sequence.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       imem_ready, dmem_ready, branch_taken;
  logic [1:0] ALUOp, alu_src_a, alu_src_b, wb_sel;
  logic       pc_src, pc_write, ir_write, reg_write;
  logic       imem_req, dmem_req, dmem_we, instr_retire;
`ifdef MCTRL_TRAP_EN
  logic       illegal_instr;
`endif

  multicycle_main_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .ALUOp        (ALUOp),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_src       (pc_src),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .instr_retire (instr_retire)
`ifdef MCTRL_TRAP_EN
    ,
    .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  // {ALUOp, a, b, pc_src, pc_write, ir_write, reg_write, wb_sel, imem_req, dmem_req, dmem_we, retire}
  logic [15:0] outs;
  assign outs = {ALUOp, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, reg_write,
                 wb_sel, imem_req, dmem_req, dmem_we, instr_retire};

  typedef struct packed {
    logic [6:0]  op;
    logic        imr;
    logic        dmr;
    logic        bt;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  function automatic logic [15:0] mk(input logic [1:0] aop, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic psrc, input logic pw,
                                     input logic irw, input logic rw, input logic [1:0] wb,
                                     input logic ireq, input logic dreq, input logic dwe,
                                     input logic ret);
    return {aop, sa, sb, psrc, pw, irw, rw, wb, ireq, dreq, dwe, ret};
  endfunction

  // Hand-derived expected output words per state
  logic [15:0] E_ZERO, E_FW, E_FG, E_DEC, E_EXR, E_EXI, E_LUI, E_MADDR, E_MRD;
  logic [15:0] E_MWRW, E_MWRG, E_WBA, E_WBM, E_BRT, E_BRN, E_JAL, E_JALR;

  task automatic check(input string nm, input logic [15:0] exp);
    total++;
    if (outs !== exp) begin
      bad++;
      $display("FAIL %s: outputs got=%h expected=%h", nm, outs, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", nm, got, exp);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic imr, input logic dmr, input logic bt,
                     input logic [15:0] e);
    vec_t v;
    v.op = op; v.imr = imr; v.dmr = dmr; v.bt = bt; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, compare, then advance to the next falling edge
  task automatic run_row(input vec_t v, input string nm);
    opcode       = v.op;
    imem_ready   = v.imr;
    dmem_ready   = v.dmr;
    branch_taken = v.bt;
    #1;
    check(nm, v.exp);
`ifdef MCTRL_TRAP_EN
    check_bit({nm, "_illegal"}, illegal_instr, 1'b0);
`endif
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    E_ZERO  = '0;
    E_FW    = mk(2'd0, 2'd0, 2'd2, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    E_FG    = mk(2'd0, 2'd0, 2'd2, 0, 1, 1, 0, 2'd0, 1, 0, 0, 0);
    E_DEC   = mk(2'd0, 2'd1, 2'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    E_EXR   = mk(2'd2, 2'd2, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    E_EXI   = mk(2'd3, 2'd2, 2'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    E_LUI   = mk(2'd0, 2'd3, 2'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    E_MADDR = mk(2'd0, 2'd2, 2'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    E_MRD   = mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 0);
    E_MWRW  = mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 0);
    E_MWRG  = mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 1);
    E_WBA   = mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 1);
    E_WBM   = mk(2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 2'd1, 0, 0, 0, 1);
    E_BRT   = mk(2'd1, 2'd2, 2'd0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 1);
    E_BRN   = mk(2'd1, 2'd2, 2'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 1);
    E_JAL   = mk(2'd0, 2'd0, 2'd0, 1, 1, 0, 1, 2'd2, 0, 0, 0, 1);
    E_JALR  = mk(2'd0, 2'd2, 2'd1, 0, 1, 0, 1, 2'd2, 0, 0, 0, 1);

    // RESET (ready ignored), one fetch wait, then R-type with stray readies/branch_taken
    add(OP_R, 1, 0, 0, E_ZERO);
    add(OP_R, 0, 0, 0, E_FW);
    add(OP_R, 1, 0, 0, E_FG);
    add(OP_R, 1, 1, 1, E_DEC);
    add(OP_R, 1, 1, 1, E_EXR);
    add(OP_R, 1, 1, 1, E_WBA);
    // I-type, LUI, AUIPC
    add(OP_I, 1, 0, 0, E_FG);  add(OP_I, 0, 0, 0, E_DEC);
    add(OP_I, 0, 0, 0, E_EXI); add(OP_I, 1, 0, 1, E_WBA);
    add(OP_LUI, 1, 0, 0, E_FG);  add(OP_LUI, 0, 0, 0, E_DEC);
    add(OP_LUI, 0, 0, 0, E_LUI); add(OP_LUI, 0, 0, 0, E_WBA);
    add(OP_AUI, 1, 0, 0, E_FG); add(OP_AUI, 0, 0, 0, E_DEC); add(OP_AUI, 0, 0, 0, E_WBA);
    // Load with two dmem wait cycles: 7 cycles total
    add(OP_LD, 1, 0, 0, E_FG);  add(OP_LD, 0, 0, 0, E_DEC); add(OP_LD, 0, 1, 0, E_MADDR);
    add(OP_LD, 0, 0, 0, E_MRD); add(OP_LD, 0, 0, 0, E_MRD); add(OP_LD, 0, 1, 0, E_MRD);
    add(OP_LD, 0, 0, 0, E_WBM);
    // Store with one wait cycle
    add(OP_ST, 1, 0, 0, E_FG);   add(OP_ST, 0, 0, 0, E_DEC); add(OP_ST, 0, 0, 0, E_MADDR);
    add(OP_ST, 0, 0, 0, E_MWRW); add(OP_ST, 1, 1, 0, E_MWRG);
    // Branch taken / not taken
    add(OP_BR, 1, 0, 0, E_FG); add(OP_BR, 0, 0, 1, E_DEC); add(OP_BR, 0, 0, 1, E_BRT);
    add(OP_BR, 1, 0, 0, E_FG); add(OP_BR, 0, 0, 0, E_DEC); add(OP_BR, 0, 0, 0, E_BRN);
    // JAL, JALR
    add(OP_JAL, 1, 0, 0, E_FG); add(OP_JAL, 0, 0, 0, E_DEC); add(OP_JAL, 0, 0, 0, E_JAL);
    add(OP_JR, 1, 0, 0, E_FG);  add(OP_JR, 0, 0, 0, E_DEC);  add(OP_JR, 0, 0, 0, E_JALR);
    // Illegal opcode reaches DECODE
    add(OP_BAD, 1, 0, 0, E_FG); add(OP_BAD, 0, 0, 0, E_DEC);

    rst_n = 1'b0; opcode = OP_R; imem_ready = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("in_reset", E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      run_row(vecs[i], $sformatf("row%0d", i));
    end

`ifdef MCTRL_TRAP_EN
    // TRAP absorbs regardless of fetch readiness
    for (int i = 0; i < 20; i++) begin
      imem_ready = i[0];
      #1;
      check($sformatf("trap%0d", i), E_ZERO);
      check_bit($sformatf("trap%0d_illegal", i), illegal_instr, 1'b1);
      @(negedge clk);
    end
`else
    // Illegal opcode returns to FETCH in cycle 3 with no retire
    v = '{op: OP_BAD, imr: 1'b0, dmr: 1'b0, bt: 1'b0, exp: E_FW};
    run_row(v, "illegal_nop_fetch");
`endif

    // Reset mid-store: request must drop asynchronously
    rst_n = 1'b0;
    #1 check("reset_assert", E_ZERO);
`ifdef MCTRL_TRAP_EN
    check_bit("reset_clears_illegal", illegal_instr, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    v = '{op: OP_ST, imr: 1'b1, dmr: 1'b0, bt: 1'b0, exp: E_ZERO};  run_row(v, "st_reset");
    v = '{op: OP_ST, imr: 1'b1, dmr: 1'b0, bt: 1'b0, exp: E_FG};    run_row(v, "st_fetch");
    v = '{op: OP_ST, imr: 1'b0, dmr: 1'b0, bt: 1'b0, exp: E_DEC};   run_row(v, "st_decode");
    v = '{op: OP_ST, imr: 1'b0, dmr: 1'b0, bt: 1'b0, exp: E_MADDR}; run_row(v, "st_addr");
    #1 check("st_memwr_pending", E_MWRW);
    #2 rst_n = 1'b0;
    #1 check("async_drop_dmem_req", E_ZERO);
    check_bit("async_dmem_req_low", dmem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{op: OP_R, imr: 1'b0, dmr: 1'b0, bt: 1'b0, exp: E_ZERO}; run_row(v, "restart_reset");
    v = '{op: OP_R, imr: 1'b0, dmr: 1'b0, bt: 1'b0, exp: E_FW};   run_row(v, "restart_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
